// File: rtl/renkon_pool_writer_if.sv
// ctrl_bus: start/valid/stop pulse stream between the pool datapath and its consumers.
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;

    modport master (output start, output valid, output stop);
    modport slave  (input  start, input  valid, input  stop);
endinterface

// File: rtl/renkon_pool_writer.sv
// renkon_pool_writer: turns the pool stage's start/valid/stop stream into linear
// writes to the output feature RAM, checks the write count against out_size^2
// and pulses ack to the layer sequencer when the frame is done.
// Optional feature: define RENKON_POOL_WRITER_RELU_EN to clamp negative data to 0.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_WAIT   | idle, waiting for a start; ack pulses here after a frame
//   S_ACTIVE | frame open, each valid becomes one write (until count full)
//   S_FLUSH  | one cycle after stop; last write may still be on the port
module renkon_pool_writer #(
    parameter int LWIDTH = 10,
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              xrst,
    ctrl_bus.slave            in_ctrl,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [LWIDTH-1:0] out_size,
    input  logic [AWIDTH-1:0] base_addr,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              busy,
    output logic              ack,
    output logic              err
);

    localparam int CW = 2 * LWIDTH;

    typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_FLUSH} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_expect;
    logic [CW-1:0]     r_cnt;
    logic [AWIDTH-1:0] r_base;
    logic              r_mem_we;
    logic [AWIDTH-1:0] r_mem_addr;
    logic [DWIDTH-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_ack;
    logic              r_err;

    logic [CW-1:0]     w_expect;
    logic              w_room;
    logic              w_wr;
    logic [CW-1:0]     w_cnt_next;
    logic [AWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_wdata;

    // Frame size is squared once at start so the per-beat compare is a plain magnitude check.
    assign w_expect   = CW'(out_size) * CW'(out_size);
    assign w_room     = (r_cnt < r_expect);
    assign w_wr       = in_ctrl.valid && w_room;
    // Count including a valid in this cycle, so a same-cycle valid+stop is judged correctly.
    assign w_cnt_next = r_cnt + CW'(w_wr);
    // Address wraps modulo 2^AWIDTH; overflow into the upper count bits is dropped on purpose.
    assign w_addr     = r_base + r_cnt[AWIDTH-1:0];

`ifdef RENKON_POOL_WRITER_RELU_EN
    assign w_wdata = in_data[DWIDTH-1] ? '0 : in_data;
`else
    assign w_wdata = in_data;
`endif

    // Frame sequencer with registered memory port and status outputs.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state     <= S_WAIT;
            r_expect    <= '0;
            r_cnt       <= '0;
            r_base      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_ack    <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (in_ctrl.start) begin
                        r_state  <= S_ACTIVE;
                        r_busy   <= 1'b1;
                        r_expect <= w_expect;
                        r_base   <= base_addr;
                        r_cnt    <= '0;
                        r_err    <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (in_ctrl.valid) begin
                        if (w_room) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_wdata;
                            r_cnt       <= w_cnt_next;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    if (in_ctrl.stop) begin
                        r_state <= S_FLUSH;
                        if (w_cnt_next != r_expect) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_WAIT;
                    r_busy  <= 1'b0;
                    r_ack   <= 1'b1;
                end
                default: begin
                    r_state <= S_WAIT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign ack       = r_ack;
    assign err       = r_err;

endmodule

// File: doc/renkon_pool_writer.md
# renkon_pool_writer

Receiving end of the pooling stage's output `ctrl_bus`. It consumes the `start`/`valid`/`stop` stream and the pooled data beside it, and generates linear write addresses into the output feature memory. It checks the write count against the expected map size and signals completion to the layer sequencer. It sits between the pool datapath and the output feature RAM port.

## Interface
Parameters:
- `LWIDTH`, 10: map-size field width.
- `DWIDTH`, 16: data word width, signed two's complement.
- `AWIDTH`, 12: output memory address width.

Ports:
- `clk`: input, 1. Clock.
- `xrst`: input, 1. Reset, asynchronous, active-low.
- `in_ctrl`: `ctrl_bus.slave`. Provides `start`, `valid` and `stop`, each 1 bit, each a single-cycle pulse.
- `in_data`: input, `DWIDTH`. Pooled value, qualified by `in_ctrl.valid` in the same cycle.
- `out_size`: input, `LWIDTH`. Output map side length, sampled on an accepted `start`.
- `base_addr`: input, `AWIDTH`. First write address, sampled on an accepted `start`.
- `mem_we`: output, 1. Write enable.
- `mem_addr`: output, `AWIDTH`. Write address.
- `mem_wdata`: output, `DWIDTH`. Write data.
- `busy`: output, 1. High in `S_ACTIVE` and `S_FLUSH`.
- `ack`: output, 1. One-cycle completion pulse.
- `err`: output, 1. Sticky count-mismatch flag.

## Operation
- States are `S_WAIT`, `S_ACTIVE` and `S_FLUSH`.
  - `S_WAIT` goes to `S_ACTIVE` on `in_ctrl.start`. This is an accepted start.
  - `S_ACTIVE` goes to `S_FLUSH` on `in_ctrl.stop`.
  - `S_FLUSH` goes to `S_WAIT` unconditionally after 1 cycle.
- On an accepted start:
  - Latch `out_size` and `base_addr`.
  - Compute `expect = out_size*out_size`, width `2*LWIDTH`.
  - Clear the write count `cnt` (width `2*LWIDTH`) and clear `err`.
- A `start` seen outside `S_WAIT` is ignored. No state, count or latched value changes.
- Writes in `S_ACTIVE`, when `in_ctrl.valid` is high:
  - If `cnt < expect`: register a write with `mem_addr = base + cnt[AWIDTH-1:0]`, computed mod 2^`AWIDTH` (the address wraps silently), and `mem_wdata = in_data`. Then `cnt <= cnt+1`.
  - If `cnt >= expect`: suppress the write and set `err`.
- `valid` outside `S_ACTIVE` is ignored. This includes a `valid` in the same cycle as an accepted `start`.
- `valid` and `stop` in the same cycle: the write is performed, then the state goes to `S_FLUSH`.
- At `stop`, `err` is set if the final count (including a same-cycle `valid`) is not equal to `expect`.
- `out_size = 0`: `expect = 0`. Every `valid` is suppressed and sets `err`.
- `err` holds until the next accepted start or reset.
- Reset forces `S_WAIT` and clears `cnt`, latched values, `err` and all outputs immediately, including mid-frame.

## Timing
- Reset values: `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `busy=0`, `ack=0`, `err=0`.
- All outputs are registered.
- Write latency: `valid` at cycle t gives `mem_we`, `mem_addr` and `mem_wdata` at t+1, for exactly one cycle per accepted `valid`.
- Back-to-back `valid` gives back-to-back writes with no bubble.
- Completion: `stop` at cycle t gives:
  - `S_FLUSH` at t+1, where the last `mem_we` can appear;
  - `ack=1` and `S_WAIT` at t+2, with `ack` lasting one cycle.
- `busy` rises at t+1 after an accepted start and falls together with the `ack` cycle.
- `err` is visible 1 cycle after the offending `valid` or `stop`.
- The earliest next accepted start is the `ack` cycle (t+2).

## Configuration
- `RENKON_POOL_WRITER_RELU_EN` defined:
  - A negative `in_data` (MSB=1) is written as 0.
  - Non-negative values pass unchanged.
  - Latency is unchanged.
- Undefined: `in_data` is written unchanged.

## Test plan
- Nominal frame: `out_size=3`, `base_addr=0x100`, start, 9 consecutive valids with data 1..9, stop with the 9th valid.
  - Writes go to 0x100..0x108, 1..9, each 1 cycle after its `valid`.
  - `ack` comes 2 cycles after `stop`; `err=0`.
- Gapped valids: `out_size=2`, valids at cycles 2, 5, 6 and 10, stop at 12.
  - 4 writes at cycles 3, 6, 7 and 11, to addresses base..base+3.
  - `ack` at cycle 14.
- Overrun and underrun:
  - `out_size=2` with 6 valids: 4 writes, 5th and 6th suppressed, `err=1` after the 5th `valid`.
  - Next start clears `err`. A frame of 3 valids then stop gives `err=1` 1 cycle after `stop`.
- Address wrap plus ignored start: `AWIDTH=12`, `base_addr=0xFFE`, `out_size=2`.
  - Writes go to 0xFFE, 0xFFF, 0x000, 0x001.
  - A `start` pulsed mid-frame changes nothing.
- Reset mid-frame: deassert `xrst` after 2 of 4 writes.
  - Outputs are 0 immediately and the block is in `S_WAIT`.
  - A new frame behaves as nominal.
- `RELU_EN` on/off: data -5, 7, -1, 0x7FFF.
  - Macro defined: writes 0, 7, 0, 0x7FFF.
  - Macro undefined: writes -5, 7, -1, 0x7FFF.
